// File: rtl/debounce_sync.sv
// debounce_sync: per-channel synchroniser plus a saturating-counter debounce FSM.
// Optional DEBOUNCE_TOGGLE_EN adds toggle_out, which flips on every accepted rising edge.
module debounce_sync #(
  parameter int WIDTH       = 1,
  parameter int CNT_MAX     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   raw_in,
  output logic [WIDTH-1:0]   db_out,
  output logic [WIDTH-1:0]   rise_pulse,
  output logic [WIDTH-1:0]   fall_pulse,
  output logic [WIDTH-1:0]   busy,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic [WIDTH-1:0]   toggle_out,
`endif
  output logic [2*WIDTH-1:0] dbg_state
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  // Plain flop chain per channel; the last stage is the only value the FSMs look at.
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          r_busy;
`ifdef DEBOUNCE_TOGGLE_EN
    logic          r_tog;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= STABLE_LO;
        r_cnt   <= '0;
        r_db    <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_busy  <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
        r_tog   <= 1'b0;
`endif
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          STABLE_LO: begin
            if (w_s[g]) begin
              r_state <= WAIT_HI;
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_HI: begin
            if (!w_s[g]) begin
              r_state <= STABLE_LO;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= STABLE_HI;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_db    <= 1'b1;
              r_rise  <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
              r_tog   <= ~r_tog;
`endif
            end else begin
              r_cnt   <= r_cnt + CNT_ONE;
            end
          end
          STABLE_HI: begin
            if (!w_s[g]) begin
              r_state <= WAIT_LO;
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_LO: begin
            if (w_s[g]) begin
              r_state <= STABLE_HI;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= STABLE_LO;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_db    <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign db_out[g]          = r_db;
    assign rise_pulse[g]      = r_rise;
    assign fall_pulse[g]      = r_fall;
    assign busy[g]            = r_busy;
    assign dbg_state[2*g +: 2] = r_state;
`ifdef DEBOUNCE_TOGGLE_EN
    assign toggle_out[g]      = r_tog;
`endif
  end

endmodule
